// File: rtl/local_bus_decoder_pkg.sv
// Shared types and constants for the local bus decoder.
package local_bus_decoder_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/local_bus_decoder_timer.sv
// Slave-ack watchdog: counts enabled cycles from 0 and flags the terminal count.
module local_bus_decoder_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn)                 count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + CW'(1);
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/local_bus_decoder.sv
// Routes single-master local bus accesses to NUM_SLV slaves by address field; error-acks unmapped accesses.
// Define LOCAL_BUS_DECODER_TIMEOUT_EN to error-ack slaves that do not answer within TIMEOUT_CYCLES.
module local_bus_decoder
  import local_bus_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLV        = 4,
  parameter int SEL_LSB        = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic                          aclk,
  input  logic                          resetn,
  input  logic [ADDR_WIDTH-1:0]         s_local_addr,
  input  logic                          s_local_wr_en,
  input  logic [DATA_WIDTH-1:0]         s_local_wr_data,
  output logic                          s_local_wr_ack,
  input  logic                          s_local_rd_en,
  output logic [DATA_WIDTH-1:0]         s_local_rd_data,
  output logic                          s_local_rd_ack,
  output logic [ADDR_WIDTH-1:0]         m_local_addr,
  output logic [NUM_SLV-1:0]            m_local_wr_en,
  output logic [DATA_WIDTH-1:0]         m_local_wr_data,
  input  logic [NUM_SLV-1:0]            m_local_wr_ack,
  output logic [NUM_SLV-1:0]            m_local_rd_en,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] m_local_rd_data,
  input  logic [NUM_SLV-1:0]            m_local_rd_ack,
  output logic                          err_unmapped,
  output logic                          err_timeout
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_t            state_q, state_d;
  logic              dir_wr_q;
  logic [SEL_W-1:0]  idx_q;
  logic [SEL_W-1:0]  sel;
  logic              req, mapped, hit, expired, timed_out;
  logic [DATA_WIDTH-1:0] rd_slice [NUM_SLV];

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_slice
    assign rd_slice[i] = m_local_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req    = s_local_wr_en | s_local_rd_en;
  assign sel    = s_local_addr[SEL_LSB +: SEL_W];
  assign mapped = (32'(sel) < 32'(NUM_SLV)) && ((s_local_addr >> (SEL_LSB + SEL_W)) == '0);

  // A slave may ack in the same cycle it sees its enable, so ISSUE listens too.
  assign hit = ((state_q == ISSUE) || (state_q == WAIT)) &&
               (dir_wr_q ? m_local_wr_ack[idx_q] : m_local_rd_ack[idx_q]);
  assign timed_out = (state_q == WAIT) && !hit && expired;

`ifdef LOCAL_BUS_DECODER_TIMEOUT_EN
  local_bus_decoder_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .aclk    (aclk),
    .resetn  (resetn),
    .clear   (state_q != WAIT),
    .enable  (state_q == WAIT),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    m_local_wr_en = '0;
    m_local_rd_en = '0;
    case (state_q)
      IDLE:  if (req) state_d = mapped ? ISSUE : ERR;
      ISSUE: begin
        if (dir_wr_q) m_local_wr_en[idx_q] = 1'b1;
        else          m_local_rd_en[idx_q] = 1'b1;
        state_d = hit ? IDLE : WAIT;
      end
      WAIT:  if (hit || timed_out) state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      dir_wr_q        <= 1'b0;
      idx_q           <= '0;
      m_local_addr    <= '0;
      m_local_wr_data <= '0;
      s_local_wr_ack  <= 1'b0;
      s_local_rd_ack  <= 1'b0;
      s_local_rd_data <= '0;
      err_unmapped    <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_local_wr_ack <= 1'b0;
      s_local_rd_ack <= 1'b0;
      err_unmapped   <= 1'b0;
      err_timeout    <= 1'b0;
      if (state_q == IDLE && req) begin
        m_local_addr    <= s_local_addr;
        m_local_wr_data <= s_local_wr_data;
        dir_wr_q        <= s_local_wr_en;
        idx_q           <= sel;
        // Unmapped: answer straight away; the ERR state only burns the ack cycle.
        if (!mapped) begin
          s_local_wr_ack <= s_local_wr_en;
          s_local_rd_ack <= !s_local_wr_en;
          err_unmapped   <= 1'b1;
          if (!s_local_wr_en) s_local_rd_data <= ERR_DATA;
        end
      end
      if (hit) begin
        s_local_wr_ack <= dir_wr_q;
        s_local_rd_ack <= !dir_wr_q;
        if (!dir_wr_q) s_local_rd_data <= rd_slice[idx_q];
      end
      if (timed_out) begin
        s_local_wr_ack <= dir_wr_q;
        s_local_rd_ack <= !dir_wr_q;
        err_timeout    <= 1'b1;
        if (!dir_wr_q) s_local_rd_data <= ERR_DATA;
      end
    end
  end
endmodule

// File: tb/tb_local_bus_decoder.sv
// Directed bench: stimulus pushes expected upstream responses, a negedge monitor pops and checks them.
module tb_local_bus_decoder;
  logic         aclk = 1'b0;
  logic         resetn;
  logic [23:0]  s_local_addr;
  logic         s_local_wr_en, s_local_rd_en;
  logic [31:0]  s_local_wr_data;
  logic         s_local_wr_ack, s_local_rd_ack;
  logic [31:0]  s_local_rd_data;
  logic [23:0]  m_local_addr;
  logic [3:0]   m_local_wr_en, m_local_rd_en;
  logic [31:0]  m_local_wr_data;
  logic [3:0]   m_local_wr_ack, m_local_rd_ack;
  logic [127:0] m_local_rd_data;
  logic         err_unmapped, err_timeout;

  local_bus_decoder #(
    .ADDR_WIDTH(24), .DATA_WIDTH(32), .NUM_SLV(4), .SEL_LSB(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .s_local_addr(s_local_addr), .s_local_wr_en(s_local_wr_en), .s_local_wr_data(s_local_wr_data),
    .s_local_wr_ack(s_local_wr_ack), .s_local_rd_en(s_local_rd_en), .s_local_rd_data(s_local_rd_data),
    .s_local_rd_ack(s_local_rd_ack), .m_local_addr(m_local_addr), .m_local_wr_en(m_local_wr_en),
    .m_local_wr_data(m_local_wr_data), .m_local_wr_ack(m_local_wr_ack), .m_local_rd_en(m_local_rd_en),
    .m_local_rd_data(m_local_rd_data), .m_local_rd_ack(m_local_rd_ack),
    .err_unmapped(err_unmapped), .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        unm;
    logic        tmo;
    int          at;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] d, input logic unm, input logic tmo, input int at);
    exp_t e;
    e.wr = wr; e.data = d; e.unm = unm; e.tmo = tmo; e.at = at;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Presents one upstream pulse on the next negedge; returns one cycle later (issue cycle).
  task automatic issue(input logic wr, input logic rd, input logic [23:0] a, input logic [31:0] d);
    @(negedge aclk);
    s_local_addr = a; s_local_wr_data = d; s_local_wr_en = wr; s_local_rd_en = rd;
    @(negedge aclk);
    s_local_wr_en = 1'b0; s_local_rd_en = 1'b0;
  endtask

  // Monitor: every upstream ack must match the head of the scoreboard.
  always @(negedge aclk) begin
    if (resetn) begin
      if (s_local_wr_ack || s_local_rd_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {62'd0, s_local_wr_ack, s_local_rd_ack}, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.at));
          chk("ack_kind", {62'd0, s_local_wr_ack, s_local_rd_ack}, {62'd0, e.wr, !e.wr});
          if (!e.wr) chk("rd_data", 64'(s_local_rd_data), 64'(e.data));
          chk("err_flags", {62'd0, err_unmapped, err_timeout}, {62'd0, e.unm, e.tmo});
        end
      end else if (err_unmapped || err_timeout) begin
        chk("stray_err", {62'd0, err_unmapped, err_timeout}, 64'd0);
      end
    end
  end

  int t;

  initial begin
    resetn = 1'b0;
    s_local_addr = '0; s_local_wr_en = 0; s_local_rd_en = 0; s_local_wr_data = '0;
    m_local_wr_ack = '0; m_local_rd_ack = '0;
    m_local_rd_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    tick(3);
    chk("reset_outs", {m_local_addr, m_local_wr_en, m_local_rd_en, m_local_wr_data},
        64'd0);
    chk("reset_up", {28'd0, s_local_rd_data, s_local_wr_ack, s_local_rd_ack, err_unmapped, err_timeout},
        64'd0);
    resetn = 1'b1;
    tick(2);

    // Write slave2, acked three cycles after its enable.
    t = cyc + 1;
    push(1'b1, 32'h0, 1'b0, 1'b0, t + 5);
    issue(1'b1, 1'b0, 24'h02_0010, 32'h1234_5678);
    chk("wr_en_s2", 64'(m_local_wr_en), 64'h4);
    chk("rd_en_idle", 64'(m_local_rd_en), 64'h0);
    chk("wr_data", 64'(m_local_wr_data), 64'h1234_5678);
    chk("m_addr", 64'(m_local_addr), 64'h02_0010);
    tick(1);
    chk("wr_en_pulse", 64'(m_local_wr_en), 64'h0);
    tick(2);
    m_local_wr_ack[2] = 1'b1; tick(1); m_local_wr_ack = '0;
    tick(2);

    // Read slave1 with an immediate ack: minimum round trip.
    t = cyc + 1;
    m_local_rd_data[63:32] = 32'hCAFE_0001;
    push(1'b0, 32'hCAFE_0001, 1'b0, 1'b0, t + 2);
    issue(1'b0, 1'b1, 24'h01_0004, 32'h0);
    chk("rd_en_s1", 64'(m_local_rd_en), 64'h2);
    m_local_rd_ack[1] = 1'b1; tick(1); m_local_rd_ack = '0;
    tick(2);

    // Unmapped write: error ack next cycle, read data untouched.
    t = cyc + 1;
    push(1'b1, 32'h0, 1'b1, 1'b0, t + 1);
    issue(1'b1, 1'b0, 24'h10_0000, 32'h5555_AAAA);
    chk("unm_wr_noen", 64'({m_local_wr_en, m_local_rd_en}), 64'h0);
    chk("rd_data_hold", 64'(s_local_rd_data), 64'hCAFE_0001);
    tick(2);

    // Unmapped read (top address bit set).
    t = cyc + 1;
    push(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, t + 1);
    issue(1'b0, 1'b1, 24'h80_0000, 32'h0);
    chk("unm_rd_noen", 64'({m_local_wr_en, m_local_rd_en}), 64'h0);
    tick(2);

`ifdef LOCAL_BUS_DECODER_TIMEOUT_EN
    // Slave3 silent: error ack 17 cycles after its enable; late ack ignored.
    t = cyc + 1;
    push(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, t + 18);
    issue(1'b0, 1'b1, 24'h03_0000, 32'h0);
    chk("rd_en_s3", 64'(m_local_rd_en), 64'h8);
    tick(20);
    m_local_rd_ack[3] = 1'b1; tick(1); m_local_rd_ack = '0;
    tick(3);
    // Ack on the terminal count wins over the timeout.
    t = cyc + 1;
    push(1'b0, 32'h3333_0003, 1'b0, 1'b0, t + 18);
    issue(1'b0, 1'b1, 24'h03_0000, 32'h0);
    tick(16);
    m_local_rd_ack[3] = 1'b1; tick(1); m_local_rd_ack = '0;
    tick(3);
`else
    // Without the watchdog a slow slave is simply waited for.
    t = cyc + 1;
    push(1'b0, 32'h3333_0003, 1'b0, 1'b0, t + 22);
    issue(1'b0, 1'b1, 24'h03_0000, 32'h0);
    chk("rd_en_s3", 64'(m_local_rd_en), 64'h8);
    tick(20);
    m_local_rd_ack[3] = 1'b1; tick(1); m_local_rd_ack = '0;
    tick(3);
`endif

    // Write slave0: foreign wr_ack and wrong-direction rd_ack must be ignored.
    t = cyc + 1;
    push(1'b1, 32'h0, 1'b0, 1'b0, t + 5);
    issue(1'b1, 1'b0, 24'h00_0020, 32'h0BAD_F00D);
    chk("wr_en_s0", 64'(m_local_wr_en), 64'h1);
    m_local_wr_ack = 4'b0010; m_local_rd_ack = 4'b0001;
    tick(2);
    m_local_wr_ack = '0; m_local_rd_ack = '0;
    tick(1);
    m_local_wr_ack[0] = 1'b1; tick(1); m_local_wr_ack = '0;
    tick(2);

    // Simultaneous write and read: write wins.
    t = cyc + 1;
    push(1'b1, 32'h0, 1'b0, 1'b0, t + 2);
    issue(1'b1, 1'b1, 24'h01_0000, 32'h7777_0001);
    chk("both_wr_en", 64'(m_local_wr_en), 64'h2);
    chk("both_rd_drop", 64'(m_local_rd_en), 64'h0);
    m_local_wr_ack[1] = 1'b1; tick(1); m_local_wr_ack = '0;
    tick(2);

    // Reset while waiting on slave2: outputs clear at once, later ack ignored.
    issue(1'b0, 1'b1, 24'h02_0000, 32'h0);
    tick(1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_m", {m_local_addr, m_local_wr_en, m_local_rd_en, m_local_wr_data}, 64'd0);
    chk("rst_mid_s", {28'd0, s_local_rd_data, s_local_wr_ack, s_local_rd_ack, err_unmapped, err_timeout},
        64'd0);
    tick(1);
    resetn = 1'b1;
    tick(1);
    m_local_rd_ack[2] = 1'b1; tick(1); m_local_rd_ack = '0;
    chk("rst_no_en", 64'({m_local_wr_en, m_local_rd_en}), 64'h0);
    tick(5);

    chk("pending", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
